// File: rtl/fft_sample_buffer.sv
// -----------------------------------------------------------------------------
// fft_sample_buffer
//
// Frame buffer that collects N = 2**LOG2N complex samples and then streams
// them out in memory-address order. With BITREV=1 each sample is written to
// the bit-reversed address of its arrival index, so the output order is the
// bit-reversed input order expected by an in-place radix-2 FFT. A frame is
// only ever drained after exactly N samples have been accepted.
//
// Parameters
//   DW      width of each real / imaginary component
//   LOG2N   log2 of the frame length (1..6)
//   BITREV  1 = bit-reversed write addressing, 0 = natural order
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous frame abort (back to LOAD, counters cleared)
//   in_valid   input sample present
//   in_ready   buffer accepts an input sample this cycle
//   in_re      input sample, real part
//   in_im      input sample, imaginary part
//   out_valid  output sample present
//   out_ready  downstream accepts the output sample
//   out_re     output sample, real part (0 when out_valid=0)
//   out_im     output sample, imaginary part (0 when out_valid=0)
//   out_idx    memory address of the current output sample
//   out_last   current output sample is the last of the frame
//   frame_cnt  number of fully drained frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fft_sample_buffer #(
    parameter int DW     = 8,
    parameter int LOG2N  = 3,
    parameter bit BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic [7:0]       frame_cnt
);

    localparam int               N        = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] IDX_ZERO = LOG2N'(0);
    localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Mirror the address bits: bit i of the result is bit LOG2N-1-i of a.
    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [0:0]       state_r;
    logic [LOG2N-1:0] wr_cnt_r;
    logic [LOG2N-1:0] rd_cnt_r;
    logic [7:0]       frame_cnt_r;
    logic [2*DW-1:0]  mem_r [N];

    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             transfer_s;
    logic [LOG2N-1:0] wr_addr_s;
    logic [2*DW-1:0]  rd_data_s;

    // Handshake qualifiers: reset and flush suppress both sides immediately,
    // so nothing is accepted or transferred in a cycle that aborts the frame.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        if (rst || flush) begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    in_ready_s  = 1'b1;
                    out_valid_s = 1'b0;
                end
                ST_DRAIN: begin
                    in_ready_s  = 1'b0;
                    out_valid_s = 1'b1;
                end
                default: begin
                    in_ready_s  = 1'b0;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign accept_s   = in_valid && in_ready_s;
    assign transfer_s = out_valid_s && out_ready;
    assign rd_data_s  = mem_r[rd_cnt_r];

    // Write address selection: bit-reversed arrival index or natural order.
    always_comb begin
        wr_addr_s = wr_cnt_r;
        if (BITREV) begin
            wr_addr_s = bit_reverse(wr_cnt_r);
        end else begin
            wr_addr_s = wr_cnt_r;
        end
    end

    // Output data path: shows the addressed entry while draining, zeros otherwise.
    always_comb begin
        out_re   = {DW{1'b0}};
        out_im   = {DW{1'b0}};
        out_idx  = IDX_ZERO;
        out_last = 1'b0;
        if (out_valid_s) begin
            out_re   = rd_data_s[2*DW-1:DW];
            out_im   = rd_data_s[DW-1:0];
            out_idx  = rd_cnt_r;
            out_last = (rd_cnt_r == LAST_IDX);
        end else begin
            out_re   = {DW{1'b0}};
            out_im   = {DW{1'b0}};
            out_idx  = IDX_ZERO;
            out_last = 1'b0;
        end
    end

    // Sample storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_addr_s] <= {in_re, in_im};
        end
    end

    // Frame control FSM with write/read counters and the drained-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            wr_cnt_r    <= IDX_ZERO;
            rd_cnt_r    <= IDX_ZERO;
            frame_cnt_r <= 8'd0;
        end else if (flush) begin
            // Abort the frame in progress; completed-frame count is kept.
            state_r  <= ST_LOAD;
            wr_cnt_r <= IDX_ZERO;
            rd_cnt_r <= IDX_ZERO;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (wr_cnt_r == LAST_IDX) begin
                            state_r  <= ST_DRAIN;
                            wr_cnt_r <= IDX_ZERO;
                            rd_cnt_r <= IDX_ZERO;
                        end else begin
                            wr_cnt_r <= wr_cnt_r + IDX_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (transfer_s) begin
                        if (rd_cnt_r == LAST_IDX) begin
                            state_r     <= ST_LOAD;
                            rd_cnt_r    <= IDX_ZERO;
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                        end else begin
                            rd_cnt_r <= rd_cnt_r + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_LOAD;
                    wr_cnt_r <= IDX_ZERO;
                    rd_cnt_r <= IDX_ZERO;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_sample_buffer
//
// Directed bench for fft_sample_buffer. Two instances share all inputs: one
// with bit-reversed write addressing, one in natural order. When a full frame
// has been loaded the expected output sequence of each instance is pushed to
// its own queue; entries are compared against the DUT while draining and
// popped on every output transfer.
// -----------------------------------------------------------------------------
module tb_fft_sample_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_re;
    logic [7:0] in_im;

    logic       br_in_ready,  nat_in_ready;
    logic       br_out_valid, nat_out_valid;
    logic [7:0] br_out_re,    nat_out_re;
    logic [7:0] br_out_im,    nat_out_im;
    logic [2:0] br_out_idx,   nat_out_idx;
    logic       br_out_last,  nat_out_last;
    logic [7:0] br_frame_cnt, nat_frame_cnt;

    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    exp_t       q_br[$];
    exp_t       q_nat[$];
    logic [7:0] frm_re [8];
    logic [7:0] frm_im [8];
    logic [7:0] exp_fc;
    int         checks   = 0;
    int         failures = 0;

    fft_sample_buffer #(.DW(8), .LOG2N(3), .BITREV(1'b1)) u_br (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(br_in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(br_out_valid), .out_ready(out_ready),
        .out_re(br_out_re), .out_im(br_out_im),
        .out_idx(br_out_idx), .out_last(br_out_last),
        .frame_cnt(br_frame_cnt)
    );

    fft_sample_buffer #(.DW(8), .LOG2N(3), .BITREV(1'b0)) u_nat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nat_in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(nat_out_valid), .out_ready(out_ready),
        .out_re(nat_out_re), .out_im(nat_out_im),
        .out_idx(nat_out_idx), .out_last(nat_out_last),
        .frame_cnt(nat_frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [2:0] rev3(input logic [2:0] a);
        return {a[0], a[1], a[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic fl, input logic v,
                         input logic [7:0] re, input logic [7:0] im, input logic ordy);
        @(negedge clk);
        rst       = r;
        flush     = fl;
        in_valid  = v;
        in_re     = re;
        in_im     = im;
        out_ready = ordy;
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_br_valid"},  32'(br_out_valid),  32'd0);
        chk({tag, "_br_re"},     32'(br_out_re),     32'd0);
        chk({tag, "_br_im"},     32'(br_out_im),     32'd0);
        chk({tag, "_br_idx"},    32'(br_out_idx),    32'd0);
        chk({tag, "_br_last"},   32'(br_out_last),   32'd0);
        chk({tag, "_nat_valid"}, 32'(nat_out_valid), 32'd0);
        chk({tag, "_nat_re"},    32'(nat_out_re),    32'd0);
        chk({tag, "_nat_im"},    32'(nat_out_im),    32'd0);
        chk({tag, "_nat_idx"},   32'(nat_out_idx),   32'd0);
        chk({tag, "_nat_last"},  32'(nat_out_last),  32'd0);
    endtask

    // Present samples base+k one per cycle; a full frame queues expectations.
    task automatic load_samples(input int count, input logic [7:0] base_re, input logic [7:0] base_im);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            drive(1'b0, 1'b0, 1'b1, base_re + 8'(k), base_im + 8'(k), 1'b1);
            chk("load_br_ready",  32'(br_in_ready),  32'd1);
            chk("load_nat_ready", 32'(nat_in_ready), 32'd1);
            check_idle("load");
            frm_re[k] = base_re + 8'(k);
            frm_im[k] = base_im + 8'(k);
        end
        if (count == 8) begin
            for (int j = 0; j < 8; j++) begin
                e.idx  = 3'(j);
                e.last = (j == 7);
                e.re   = frm_re[rev3(3'(j))];
                e.im   = frm_im[rev3(3'(j))];
                q_br.push_back(e);
                e.re   = frm_re[j];
                e.im   = frm_im[j];
                q_nat.push_back(e);
            end
        end
    endtask

    // Run drain cycles until n_xfer transfers occurred; stall_mode 1 gives
    // out_ready 1,0,0,1,0,0,... Junk input is offered every cycle.
    task automatic xfer_cycles(input int n_xfer, input int stall_mode);
        int   guard = 0;
        int   pops  = 0;
        logic ordy;
        exp_t e;
        while (pops < n_xfer && guard < 64) begin
            ordy = (stall_mode == 0) ? 1'b1 : ((guard % 3) == 0);
            drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), ordy);
            chk("drain_br_ready",  32'(br_in_ready),   32'd0);
            chk("drain_nat_ready", 32'(nat_in_ready),  32'd0);
            chk("drain_br_valid",  32'(br_out_valid),  32'd1);
            chk("drain_nat_valid", 32'(nat_out_valid), 32'd1);
            if (q_br.size() > 0) begin
                e = q_br[0];
                chk("br_out_re",   32'(br_out_re),   32'(e.re));
                chk("br_out_im",   32'(br_out_im),   32'(e.im));
                chk("br_out_idx",  32'(br_out_idx),  32'(e.idx));
                chk("br_out_last", 32'(br_out_last), 32'(e.last));
                if (ordy) void'(q_br.pop_front());
            end
            if (q_nat.size() > 0) begin
                e = q_nat[0];
                chk("nat_out_re",   32'(nat_out_re),   32'(e.re));
                chk("nat_out_im",   32'(nat_out_im),   32'(e.im));
                chk("nat_out_idx",  32'(nat_out_idx),  32'(e.idx));
                chk("nat_out_last", 32'(nat_out_last), 32'(e.last));
                if (ordy) void'(q_nat.pop_front());
            end
            if (ordy) pops++;
            guard++;
        end
        chk("xfer_count", 32'(pops), 32'(n_xfer));
    endtask

    // Drain a whole frame and confirm the return to LOAD and the frame count.
    task automatic drain(input int stall_mode);
        xfer_cycles(8, stall_mode);
        chk("drain_left_br",  32'(q_br.size()),  32'd0);
        chk("drain_left_nat", 32'(q_nat.size()), 32'd0);
        exp_fc = exp_fc + 8'd1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        check_idle("post_drain");
        chk("post_drain_br_ready",  32'(br_in_ready),   32'd1);
        chk("post_drain_nat_ready", 32'(nat_in_ready),  32'd1);
        chk("br_frame_cnt",         32'(br_frame_cnt),  32'(exp_fc));
        chk("nat_frame_cnt",        32'(nat_frame_cnt), 32'(exp_fc));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_re = 8'd0; in_im = 8'd0;
        exp_fc = 8'd0;

        // Reset: everything quiet while held, ready right after release.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'd5, 8'd6, 1'b1);
            check_idle("rst");
            chk("rst_br_ready",  32'(br_in_ready),  32'd0);
            chk("rst_nat_ready", 32'(nat_in_ready), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        chk("rel_br_ready",  32'(br_in_ready),   32'd1);
        chk("rel_nat_ready", 32'(nat_in_ready),  32'd1);
        chk("rel_br_fc",     32'(br_frame_cnt),  32'd0);
        chk("rel_nat_fc",    32'(nat_frame_cnt), 32'd0);
        check_idle("rel");

        // Basic frame: re=0..7, im=F0..F7, full-rate drain.
        load_samples(8, 8'h00, 8'hF0);
        drain(0);

        // Stalled drain with junk input offered throughout.
        load_samples(8, 8'h30, 8'h80);
        drain(1);

        // Flush after a partial frame; only the following full frame drains.
        load_samples(5, 8'h50, 8'h60);
        drive(1'b0, 1'b1, 1'b1, 8'hAA, 8'hBB, 1'b1);
        chk("flush_br_ready",  32'(br_in_ready),   32'd0);
        chk("flush_nat_ready", 32'(nat_in_ready),  32'd0);
        check_idle("flush");
        chk("flush_br_fc",     32'(br_frame_cnt),  32'(exp_fc));
        load_samples(8, 8'd10, 8'h40);
        drain(0);

        // Flush in the middle of a drain abandons the rest of the frame.
        load_samples(8, 8'h70, 8'h11);
        xfer_cycles(3, 0);
        drive(1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 1'b1);
        check_idle("flush_drain");
        chk("flush_drain_br_ready", 32'(br_in_ready), 32'd0);
        q_br.delete();
        q_nat.delete();
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        check_idle("after_flush_drain");
        chk("after_flush_br_ready", 32'(br_in_ready),  32'd1);
        chk("after_flush_br_fc",    32'(br_frame_cnt), 32'(exp_fc));
        chk("after_flush_nat_fc",   32'(nat_frame_cnt), 32'(exp_fc));

        // Reset at the third output transfer.
        load_samples(8, 8'h90, 8'hC0);
        xfer_cycles(2, 0);
        drive(1'b1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b1);
        check_idle("rst_drain");
        chk("rst_drain_br_ready", 32'(br_in_ready), 32'd0);
        q_br.delete();
        q_nat.delete();
        exp_fc = 8'd0;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        check_idle("after_rst");
        chk("after_rst_br_ready",  32'(br_in_ready),   32'd1);
        chk("after_rst_nat_ready", 32'(nat_in_ready),  32'd1);
        chk("after_rst_br_fc",     32'(br_frame_cnt),  32'd0);
        chk("after_rst_nat_fc",    32'(nat_frame_cnt), 32'd0);

        // 256 frames: exercises the frame counter wrap 255 -> 0.
        for (int f = 0; f < 256; f++) begin
            load_samples(8, 8'(f), 8'(f * 3));
            drain(0);
        end
        chk("wrap_br_fc", 32'(br_frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
